img_rom_arbiter: RTL and testbench

- Shares one synchronous-read image ROM (16-bit RGB565 words, 1-cycle read latency, 320x240 = 76800 words) between two requesters.
- Port 0 is the real-time VGA pixel fetcher; port 1 is a background reader (filter engine / UART dump).
- Fixed priority to port 0, with a starvation guard that forces one port-1 grant after STARVE_LIMIT blocked cycles.
- Tracks ROM latency internally and returns each word, registered, to the requester that issued it.

---
 rtl/img_rom_arbiter_if.sv | 38 +++
 rtl/img_rom_arbiter.sv | 108 ++++++++++
 tb/tb_img_rom_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/img_rom_arbiter_if.sv
// Bus bundle between the image-ROM arbiter, its two requesters and the ROM.
// slave  : arbiter side (takes requests and ROM data, drives grants, read data, status)
// master : requester/ROM side (drives requests and ROM data, observes the rest)
interface img_rom_arbiter_if #(
    parameter int unsigned ADDR_W = 17
);
    logic              p0_req;
    logic [ADDR_W-1:0] p0_addr;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [15:0]       p0_rdata;

    logic              p1_req;
    logic [ADDR_W-1:0] p1_addr;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [15:0]       p1_rdata;

    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;

    logic [15:0]       p0_miss_cnt;
    logic              starve_flag;

    modport slave (
        input  p0_req, p0_addr, p1_req, p1_addr, rom_data,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output rom_addr, p0_miss_cnt, starve_flag
    );

    modport master (
        output p0_req, p0_addr, p1_req, p1_addr, rom_data,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  rom_addr, p0_miss_cnt, starve_flag
    );
endinterface

// File: rtl/img_rom_arbiter.sv
// Two-port arbiter in front of a 1-cycle synchronous-read RGB565 image ROM.
// Port 0 (VGA fetch) has fixed priority; port 1 (background reader) is forced
// through once it has been blocked STARVE_LIMIT consecutive cycles.
// Read data returns registered, 2 cycles after the grant, to the issuing port.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : slave side of img_rom_arbiter_if
//            p0/p1 req, addr -> gnt (combinational), rvalid, rdata (registered)
//            rom_addr (combinational) / rom_data (from ROM, one cycle later)
//            p0_miss_cnt (saturating), starve_flag (registered forced-grant flag)
module img_rom_arbiter #(
    parameter int unsigned H_SIZE       = 320,
    parameter int unsigned V_SIZE       = 240,
    parameter int unsigned ADDR_W       = $clog2(H_SIZE * V_SIZE),
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic           clk,
    input  logic           reset,
    img_rom_arbiter_if.slave bus
);
    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        tag_q;
    logic [15:0]       miss_cnt_q;
    logic              starve_flag_q;
    logic              p0_rvalid_q;
    logic              p1_rvalid_q;
    logic [15:0]       p0_rdata_q;
    logic [15:0]       p1_rdata_q;

    logic              force_c;
    logic              p0_gnt_c;
    logic              p1_gnt_c;
    logic [ADDR_W-1:0] rom_addr_c;
    logic [WAIT_W-1:0] wait_next_c;
    logic [15:0]       miss_next_c;

    // Grant decision and ROM address mux; everything idles while reset is high.
    always_comb begin
        force_c    = 1'b0;
        p0_gnt_c   = 1'b0;
        p1_gnt_c   = 1'b0;
        rom_addr_c = '0;
        if (!reset) begin
            force_c  = bus.p1_req && (wait_cnt >= LIMIT);
            p1_gnt_c = bus.p1_req && (!bus.p0_req || force_c);
            p0_gnt_c = bus.p0_req && !force_c;
            if (p0_gnt_c) begin
                rom_addr_c = bus.p0_addr;
            end else if (p1_gnt_c) begin
                rom_addr_c = bus.p1_addr;
            end
        end
    end

    // Next values of the saturating counters.
    always_comb begin
        wait_next_c = '0;
        miss_next_c = miss_cnt_q;
        if (bus.p1_req && !p1_gnt_c) begin
            wait_next_c = (wait_cnt == '1) ? wait_cnt : wait_cnt + WAIT_W'(1);
        end
        if (bus.p0_req && !p0_gnt_c && (miss_cnt_q != 16'hFFFF)) begin
            miss_next_c = miss_cnt_q + 16'd1;
        end
    end

    // Tag pipeline: the grant tag travels alongside the ROM's read latency, so
    // the cycle after the tag is registered rom_data belongs to that port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt      <= '0;
            tag_q         <= '0;
            miss_cnt_q    <= '0;
            starve_flag_q <= 1'b0;
            p0_rvalid_q   <= 1'b0;
            p1_rvalid_q   <= 1'b0;
            p0_rdata_q    <= '0;
            p1_rdata_q    <= '0;
        end else begin
            wait_cnt      <= wait_next_c;
            tag_q         <= {p1_gnt_c, p0_gnt_c};
            miss_cnt_q    <= miss_next_c;
            starve_flag_q <= force_c;
            p0_rvalid_q   <= tag_q[0];
            p1_rvalid_q   <= tag_q[1];
            if (tag_q[0]) begin
                p0_rdata_q <= bus.rom_data;
            end
            if (tag_q[1]) begin
                p1_rdata_q <= bus.rom_data;
            end
        end
    end

    assign bus.p0_gnt      = p0_gnt_c;
    assign bus.p1_gnt      = p1_gnt_c;
    assign bus.rom_addr    = rom_addr_c;
    assign bus.p0_rvalid   = p0_rvalid_q;
    assign bus.p1_rvalid   = p1_rvalid_q;
    assign bus.p0_rdata    = p0_rdata_q;
    assign bus.p1_rdata    = p1_rdata_q;
    assign bus.p0_miss_cnt = miss_cnt_q;
    assign bus.starve_flag = starve_flag_q;
endmodule

// File: tb/tb_img_rom_arbiter.sv
// Directed bench for img_rom_arbiter with a behavioural synchronous-read ROM.
// Inputs change and registered outputs are sampled on the falling clock edge;
// combinational grants are sampled 1 ns after inputs change.
module tb_img_rom_arbiter;
    localparam int unsigned ADDR_W = 17;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    img_rom_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    img_rom_arbiter #(
        .H_SIZE(320), .V_SIZE(240), .ADDR_W(ADDR_W), .STARVE_LIMIT(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents as a pure function of the address
    function automatic logic [15:0] rom_word(input logic [ADDR_W-1:0] a);
        return 16'(a * 17'd37) ^ a[16:1];
    endfunction

    // 1-cycle synchronous-read ROM
    always @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        bus.p0_req   = 1'b0;
        bus.p0_addr  = '0;
        bus.p1_req   = 1'b0;
        bus.p1_addr  = '0;
        bus.rom_data = '0;
        cyc();
        cyc();

        // Reset state: requests present but everything held at zero
        bus.p0_req = 1'b1; bus.p0_addr = 17'd5;
        bus.p1_req = 1'b1; bus.p1_addr = 17'd6;
        #1;
        chk("rst_p0_gnt",   32'(bus.p0_gnt), 32'd0);
        chk("rst_p1_gnt",   32'(bus.p1_gnt), 32'd0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_rvalid",   32'({bus.p0_rvalid, bus.p1_rvalid}), 32'd0);
        chk("rst_rdata",    32'({bus.p0_rdata, bus.p1_rdata}), 32'd0);
        chk("rst_miss",     32'(bus.p0_miss_cnt), 32'd0);
        chk("rst_starve",   32'(bus.starve_flag), 32'd0);
        cyc();
        reset = 1'b0; bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        cyc();

        // Port 0 streaming addresses 0,1,2
        bus.p0_req = 1'b1; bus.p0_addr = 17'd0; #1;
        chk("t1_gnt0",  32'(bus.p0_gnt), 32'd1);
        chk("t1_gnt1",  32'(bus.p1_gnt), 32'd0);
        chk("t1_addr0", 32'(bus.rom_addr), 32'd0);
        cyc();
        chk("t1_rv_early", 32'(bus.p0_rvalid), 32'd0);
        bus.p0_addr = 17'd1; #1;
        chk("t1_addr1", 32'(bus.rom_addr), 32'd1);
        cyc();
        chk("t1_rv0",   32'(bus.p0_rvalid), 32'd1);
        chk("t1_rd0",   32'(bus.p0_rdata), 32'(rom_word(17'd0)));
        chk("t1_p1rv",  32'(bus.p1_rvalid), 32'd0);
        bus.p0_addr = 17'd2; #1;
        chk("t1_addr2", 32'(bus.rom_addr), 32'd2);
        cyc();
        chk("t1_rv1", 32'(bus.p0_rvalid), 32'd1);
        chk("t1_rd1", 32'(bus.p0_rdata), 32'(rom_word(17'd1)));
        bus.p0_req = 1'b0;
        cyc();
        chk("t1_rv2", 32'(bus.p0_rvalid), 32'd1);
        chk("t1_rd2", 32'(bus.p0_rdata), 32'(rom_word(17'd2)));
        cyc();
        chk("t1_rv_end", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'd0);
        chk("t1_hold",   32'(bus.p0_rdata), 32'(rom_word(17'd2)));

        // Port 1 alone at the last pixel address
        bus.p1_req = 1'b1; bus.p1_addr = 17'd76799; #1;
        chk("t2_gnt1", 32'(bus.p1_gnt), 32'd1);
        chk("t2_gnt0", 32'(bus.p0_gnt), 32'd0);
        chk("t2_addr", 32'(bus.rom_addr), 32'd76799);
        cyc();
        bus.p1_req = 1'b0;
        chk("t2_rv_early", 32'(bus.p1_rvalid), 32'd0);
        cyc();
        chk("t2_rv1",    32'(bus.p1_rvalid), 32'd1);
        chk("t2_rd1",    32'(bus.p1_rdata), 32'(rom_word(17'd76799)));
        chk("t2_rv0",    32'(bus.p0_rvalid), 32'd0);
        chk("t2_p0hold", 32'(bus.p0_rdata), 32'(rom_word(17'd2)));
        chk("t2_starve", 32'(bus.starve_flag), 32'd0);
        cyc();
        chk("t2_rv1_end", 32'(bus.p1_rvalid), 32'd0);

        // Both requesting: 16 blocked cycles, forced p1 grant on the 17th
        bus.p0_req = 1'b1; bus.p0_addr = 17'd10;
        bus.p1_req = 1'b1; bus.p1_addr = 17'd20;
        for (int c = 1; c <= 34; c++) begin
            #1;
            chk("t3_gnt1", 32'(bus.p1_gnt), 32'(c % 17 == 0));
            chk("t3_gnt0", 32'(bus.p0_gnt), 32'(c % 17 != 0));
            cyc();
            chk("t3_starve", 32'(bus.starve_flag), 32'(c % 17 == 0));
            chk("t3_miss",   32'(bus.p0_miss_cnt), 32'(c / 17));
            if (c == 18) begin
                chk("t3_p1rv", 32'(bus.p1_rvalid), 32'd1);
                chk("t3_p1rd", 32'(bus.p1_rdata), 32'(rom_word(17'd20)));
            end
        end
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        cyc(); cyc(); cyc();

        // Alternating grants p0(100), p1(200), p0(300)
        bus.p0_req = 1'b1; bus.p0_addr = 17'd100; #1;
        chk("t4_g0a", 32'(bus.p0_gnt), 32'd1);
        cyc();
        bus.p0_req = 1'b0; bus.p1_req = 1'b1; bus.p1_addr = 17'd200; #1;
        chk("t4_g1", 32'(bus.p1_gnt), 32'd1);
        chk("t4_a1", 32'(bus.rom_addr), 32'd200);
        cyc();
        chk("t4_rv0a", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'b10);
        chk("t4_rd0a", 32'(bus.p0_rdata), 32'(rom_word(17'd100)));
        bus.p1_req = 1'b0; bus.p0_req = 1'b1; bus.p0_addr = 17'd300; #1;
        chk("t4_g0b", 32'(bus.p0_gnt), 32'd1);
        cyc();
        bus.p0_req = 1'b0;
        chk("t4_rv1", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'b01);
        chk("t4_rd1", 32'(bus.p1_rdata), 32'(rom_word(17'd200)));
        cyc();
        chk("t4_rv0b", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'b10);
        chk("t4_rd0b", 32'(bus.p0_rdata), 32'(rom_word(17'd300)));
        chk("t4_p1hold", 32'(bus.p1_rdata), 32'(rom_word(17'd200)));
        cyc();
        chk("t4_idle", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'd0);

        // Reset one cycle after a grant drops the in-flight read
        bus.p0_req = 1'b1; bus.p0_addr = 17'd50; #1;
        chk("t5_gnt", 32'(bus.p0_gnt), 32'd1);
        cyc();
        bus.p0_req = 1'b0; reset = 1'b1; #1;
        chk("t5_rst_rv",    32'({bus.p0_rvalid, bus.p1_rvalid}), 32'd0);
        chk("t5_rst_rdata", 32'({bus.p0_rdata, bus.p1_rdata}), 32'd0);
        chk("t5_rst_miss",  32'(bus.p0_miss_cnt), 32'd0);
        chk("t5_rst_addr",  32'(bus.rom_addr), 32'd0);
        cyc();
        reset = 1'b0;
        chk("t5_rv_a", 32'(bus.p0_rvalid), 32'd0);
        cyc();
        chk("t5_rv_b", 32'(bus.p0_rvalid), 32'd0);
        bus.p0_req = 1'b1; bus.p0_addr = 17'd60;
        cyc();
        bus.p0_req = 1'b0;
        chk("t5_rv_c", 32'(bus.p0_rvalid), 32'd0);
        cyc();
        chk("t5_rv_new", 32'(bus.p0_rvalid), 32'd1);
        chk("t5_rd_new", 32'(bus.p0_rdata), 32'(rom_word(17'd60)));
        cyc();

        // Miss counter saturation, preloaded near the top
        force dut.miss_cnt_q = 16'hFFFC;
        cyc();
        release dut.miss_cnt_q;
        chk("t6_preload", 32'(bus.p0_miss_cnt), 32'h0000FFFC);
        bus.p0_req = 1'b1; bus.p1_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            repeat (17) cyc();
            chk("t6_sat", 32'(bus.p0_miss_cnt), (k >= 3) ? 32'h0000FFFF : 32'h0000FFFC + 32'(k));
        end
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        cyc();
        chk("t6_final", 32'(bus.p0_miss_cnt), 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
